// File: rtl/kestrel2_pkg.sv
// ---------------------------------------------------------------------------
// kestrel2_pkg
// Shared definitions for the Kestrel-2 peripheral set.
//   KBD_ADDR              word address of the keyboard register ($FFFE >> 1)
//   STAT_VALID/OVR/FERR   bit positions in the keyboard status/data word
//   rx_state_t            PS/2 receive FSM state encoding
//   odd_parity_ok()       true when 8 data bits plus parity hold odd parity
// ---------------------------------------------------------------------------
package kestrel2_pkg;

    localparam logic [14:0] KBD_ADDR = 15'h7FFF;

    localparam int STAT_VALID = 15;
    localparam int STAT_OVR   = 14;
    localparam int STAT_FERR  = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// ---------------------------------------------------------------------------
// ps2_filter
// Conditions one raw PS/2 pin: 2-flop synchroniser, FILT_LEN-sample glitch
// filter, and a one-cycle pulse on a filtered falling edge.
//   sys_clk_i    system clock
//   sys_rst_n_i  asynchronous active-low reset (filter idles high)
//   pin_i        raw asynchronous pin
//   filt_o       filtered pin level
//   fall_o       one-cycle pulse, high in the cycle before filt_o drops
// ---------------------------------------------------------------------------
module ps2_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic sys_clk_i,
    input  logic sys_rst_n_i,
    input  logic pin_i,
    output logic filt_o,
    output logic fall_o
);

    logic [1:0]          r_sync;
    logic [FILT_LEN-1:0] r_hist;
    logic                r_filt;
    logic                w_all_one;
    logic                w_all_zero;

    assign w_all_one  = &r_hist;
    assign w_all_zero = ~|r_hist;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_sync <= 2'b11;
            r_hist <= '1;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], pin_i};
            r_hist <= {r_hist[FILT_LEN-2:0], r_sync[1]};
            // Level only moves once the whole history window agrees.
            if (w_all_one)
                r_filt <= 1'b1;
            else if (w_all_zero)
                r_filt <= 1'b0;
        end
    end

    assign filt_o = r_filt;
    // Pulse coincides with the cycle whose edge drops r_filt, so consumers
    // sample the data pin on the same edge the filtered clock falls.
    assign fall_o = r_filt & w_all_zero;

endmodule

// File: rtl/ps2_kbd_io.sv
// ---------------------------------------------------------------------------
// ps2_kbd_io
// PS/2 keyboard receiver on the J1A data bus. Deserialises device-to-host
// frames, checks start/odd-parity/stop, queues good bytes in an 8-entry FIFO
// and exposes one status/data register {valid, ovr, ferr, 5'b0, head}.
// A read pops the head; a write clears ovr (bit 14) / ferr (bit 13) W1C.
//   sys_clk_i    system clock (25 MHz)
//   sys_rst_n_i  asynchronous active-low reset
//   ps2c_i       raw PS/2 clock pin
//   ps2d_i       raw PS/2 data pin
//   dat_cyc_i    bus cycle valid
//   dat_stb_i    strobe, already address-decoded for $FFFE
//   dat_we_i     1 = write, 0 = read
//   dat_dat_i    write data
//   dat_dat_o    registered read data
//   dat_ack_o    registered one-cycle acknowledge
// ---------------------------------------------------------------------------
module ps2_kbd_io
    import kestrel2_pkg::*;
#(
    parameter int FIFO_AW  = 3,
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 50000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        ps2c_i,
    input  logic        ps2d_i,
    input  logic        dat_cyc_i,
    input  logic        dat_stb_i,
    input  logic        dat_we_i,
    input  logic [15:0] dat_dat_i,
    output logic [15:0] dat_dat_o,
    output logic        dat_ack_o
);

    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] C_DEPTH = {1'b1, {FIFO_AW{1'b0}}};
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] C_TO    = TO_W'(TIMEOUT);

    // ---------------------------------------------------------------
    // Pin conditioning
    // ---------------------------------------------------------------
    logic w_c_filt;
    logic w_fall;
    logic w_d;

    ps2_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .pin_i       (ps2c_i),
        .filt_o      (w_c_filt),
        .fall_o      (w_fall)
    );

    ps2_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .pin_i       (ps2d_i),
        .filt_o      (w_d),
        .fall_o      ()
    );

    // ---------------------------------------------------------------
    // Receive FSM and datapath
    // ---------------------------------------------------------------
    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_par;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_start;
    logic            w_shift_en;
    logic            w_par_en;
    logic            w_frame_done;
    logic            w_accept;
    logic            w_frame_err;

    // A partial frame that stalls for TIMEOUT cycles is abandoned.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == C_TO);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_d) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_frame_done = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE:   w_start      = ~w_d;
                ST_DATA:   w_shift_en   = 1'b1;
                ST_PARITY: w_par_en     = 1'b1;
                ST_STOP:   w_frame_done = 1'b1;
                default:   w_start      = 1'b0;
            endcase
        end
    end

    assign w_accept    = w_frame_done & w_d & odd_parity_ok(r_shift, r_par);
    assign w_frame_err = (w_frame_done & ~w_accept) | w_timeout;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_start)
                r_bit_cnt <= '0;
            if (w_shift_en) begin
                r_shift   <= {w_d, r_shift[7:1]};   // LSB arrives first
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_par_en)
                r_par <= w_d;
            // Saturating idle counter, restarted by every clock fall.
            if (w_fall)
                r_to_cnt <= '0;
            else if (r_to_cnt != C_TO)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Bus interface
    // ---------------------------------------------------------------
    logic        r_ack;
    logic        r_we;
    logic        r_clr_ovr;
    logic        r_clr_ferr;
    logic [15:0] r_dat;
    logic [15:0] w_status;
    logic        w_req;
    logic        w_pop;
    logic        w_wclr;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovr;
    logic               r_ferr;
    logic               w_valid;
    logic               w_full;
    logic               w_push;
    logic               w_ovr_set;

    assign w_req  = dat_cyc_i & dat_stb_i & ~r_ack;
    // Side effects land on the edge that closes the ack cycle.
    assign w_pop  = r_ack & ~r_we & w_valid;
    assign w_wclr = r_ack & r_we;

    always_comb begin
        w_status             = '0;
        w_status[STAT_VALID] = w_valid;
        w_status[STAT_OVR]   = r_ovr;
        w_status[STAT_FERR]  = r_ferr;
        w_status[7:0]        = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_ack      <= 1'b0;
            r_we       <= 1'b0;
            r_clr_ovr  <= 1'b0;
            r_clr_ferr <= 1'b0;
            r_dat      <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_we       <= dat_we_i;
                r_clr_ovr  <= dat_dat_i[STAT_OVR];
                r_clr_ferr <= dat_dat_i[STAT_FERR];
                r_dat      <= w_status;
            end
        end
    end

    assign dat_ack_o = r_ack;
    assign dat_dat_o = r_dat;

    // ---------------------------------------------------------------
    // FIFO and sticky flags
    // ---------------------------------------------------------------
    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == C_DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_accept & (~w_full | w_pop);
    assign w_ovr_set = w_accept & w_full & ~w_pop;

    always_ff @(posedge sys_clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Setting takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (w_wclr && r_clr_ovr)
                r_ovr <= 1'b0;
            if (w_frame_err)
                r_ferr <= 1'b1;
            else if (w_wclr && r_clr_ferr)
                r_ferr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_io.sv
`timescale 1ns/1ps
module tb_ps2_kbd_io;

    localparam int FILT    = 8;
    localparam int TO      = 1000;
    localparam int HP      = 24;     // PS/2 half bit period in sys_clk cycles
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wdat = '0;
    logic [15:0] rdat;
    logic        ack;

    always #20 clk = ~clk;

    ps2_kbd_io #(.FIFO_AW(3), .FILT_LEN(FILT), .TIMEOUT(TO)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .ps2c_i      (ps2c),
        .ps2d_i      (ps2d),
        .dat_cyc_i   (cyc),
        .dat_stb_i   (stb),
        .dat_we_i    (we),
        .dat_dat_i   (wdat),
        .dat_dat_o   (rdat),
        .dat_ack_o   (ack)
    );

    typedef struct packed {
        bit          chk;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_q[$];
    bit          m_ovr = 0;
    bit          m_ferr = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s = '0;
        s[15] = (m_q.size() != 0);
        s[14] = m_ovr;
        s[13] = m_ferr;
        if (m_q.size() != 0) s[7:0] = m_q[0];
        return s;
    endfunction

    // Monitor: every ack presents a word; reads are checked against the queue.
    always @(negedge clk) begin
        if (rst_n && ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got %04h, none required", rdat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk) begin
                    vectors++;
                    if (rdat !== e.val) begin
                        miscompares++;
                        $display("FAIL read_data: got %04h, required %04h", rdat, e.val);
                    end else
                        $display("read  %04h ok", rdat);
                end else
                    $display("write ack, status %04h", rdat);
            end
        end
    end

    task automatic bus_cycle(input logic w, input logic [15:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; wdat = d;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (ack !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_latency: ack=%b one cycle after strobe, required 1", ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
        @(negedge clk);
        vectors++;
        if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_width: ack=%b in second cycle, required 0", ack);
        end
    endtask

    task automatic bus_read();
        exp_t e;
        e.chk = 1'b1;
        e.val = model_status();
        exp_q.push_back(e);
        if (m_q.size() != 0) void'(m_q.pop_front());
        bus_cycle(1'b0, 16'h0000);
    endtask

    task automatic bus_write(input logic [15:0] d);
        exp_t e;
        e.chk = 1'b0;
        e.val = '0;
        exp_q.push_back(e);
        bus_cycle(1'b1, d);
        if (d[14]) m_ovr = 0;
        if (d[13]) m_ferr = 0;
        $display("write %04h", d);
    endtask

    // One PS/2 bit: data set while clock high, clock low for HP cycles.
    // pop_here issues a read whose pop edge matches the push edge of this fall
    // (fall arrives 2+FILT cycles after the pin edge).
    task automatic ps2_bit(input logic b, input bit glitch, input bit pop_here);
        @(negedge clk);
        ps2d = b;
        if (glitch) begin
            repeat (8) @(negedge clk);
            ps2c = 1'b0;
            repeat (FILT - 1) @(negedge clk);
            ps2c = 1'b1;
            repeat (HP - 8 - (FILT - 1)) @(negedge clk);
        end else
            repeat (HP) @(negedge clk);
        ps2c = 1'b0;
        if (pop_here) begin
            repeat (1 + FILT) @(negedge clk);
            bus_read();
            repeat (HP - (1 + FILT) - 2) @(negedge clk);
        end else
            repeat (HP) @(negedge clk);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop, input int glitch_bit);
        logic p;
        p = (~^d) ^ bad_par;
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], (i == glitch_bit), 0);
        ps2_bit(p, 0, 0);
        ps2_bit(~bad_stop, 0, pop_at_stop);
        ps2d = 1'b1;
        repeat (4) @(negedge clk);
        if (!bad_par && !bad_stop) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovr = 1;
        end else
            m_ferr = 1;
        $display("frame %02h bad_par=%0d bad_stop=%0d", d, bad_par, bad_stop);
    endtask

    task automatic check_reset_outputs();
        vectors++;
        if (rdat !== 16'h0000 || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: dat=%04h ack=%b, required 0000/0", rdat, ack);
        end else
            $display("reset state ok");
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr = 0;
        m_ferr = 0;
    endtask

    initial begin
        #(2_000_000 * 40);
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Good frame, then empty read
        send_frame(8'h1C, 0, 0, 0, -1);
        bus_read();
        bus_read();

        // Parity error and W1C
        send_frame(8'h1C, 1, 0, 0, -1);
        bus_read();
        bus_write(16'h2000);
        bus_read();

        // Overflow: nine frames without reading
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, -1);
        for (int i = 0; i < 9; i++) bus_read();
        bus_write(16'h4000);
        bus_read();

        // Timeout: start + 4 data bits then silence
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0, 0);
        repeat (TO + 50) @(negedge clk);
        m_ferr = 1;
        send_frame(8'hF0, 0, 0, 0, -1);
        bus_read();
        bus_read();
        bus_write(16'h2000);

        // Short glitch on the clock pin mid-frame
        send_frame(8'h5A, 0, 0, 0, 3);
        bus_read();
        bus_read();

        // Stop-bit push coinciding with a popping read while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0, -1);
        send_frame(8'hA5, 0, 0, 1, -1);
        for (int i = 0; i < DEPTH + 1; i++) bus_read();

        // Asynchronous reset in the middle of a frame
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0, 0);
        #7 rst_n = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #5 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_read();
        send_frame(8'h1C, 0, 0, 0, -1);
        bus_read();

        // Randomised traffic
        for (int n = 0; n < 25; n++) begin
            int sel;
            int nrd;
            sel = $urandom_range(0, 9);
            send_frame(8'($urandom_range(0, 255)), (sel == 0), (sel == 1), 0, -1);
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) bus_read();
            if ($urandom_range(0, 7) == 0) bus_write(16'($urandom_range(0, 3)) << 13);
        end

        // Drain and clear
        while (m_q.size() != 0) bus_read();
        bus_read();
        bus_write(16'h6000);
        bus_read();

        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
